memory_loader: RTL

Responder side of the convolution datapath's load handshake. On request it reads a `size×size` block of words from on-chip memory, starting at a word address, into a local buffer. It presents the buffer to the requesting layer controller and completes a four-phase `load_enable`/`load_done` handshake. It sits between the layer controllers (convolution, pooling) and the single-port feature/filter memory.

---
 rtl/memory_loader_if.sv | 30 +++
 rtl/memory_loader.sv | 100 ++++++++++
 2 files changed

// File: rtl/memory_loader_if.sv
// Load-handshake and memory-read signals between a layer controller, the loader and the feature/filter memory.
// The slave modport is the loader's view; the master modport is the controller/memory side.
interface memory_loader_if #(
    parameter int DATA_SZ   = 16,
    parameter int ADDR_SZ   = 16,
    parameter int BUF_DEPTH = 1024,
    parameter int CNT_W     = $clog2(BUF_DEPTH) + 1
);
    logic               load_enable;
    logic [ADDR_SZ-1:0] load_addr;
    logic [DATA_SZ-1:0] load_size;
    logic [DATA_SZ-1:0] load_out [0:BUF_DEPTH-1];
    logic               load_done;
    logic               load_busy;
    logic               load_trunc;
    logic [CNT_W-1:0]   load_count;
    logic               mem_rd;
    logic [ADDR_SZ-1:0] mem_addr;
    logic [DATA_SZ-1:0] mem_data;

    modport slave (
        input  load_enable, load_addr, load_size, mem_data,
        output load_out, load_done, load_busy, load_trunc, load_count, mem_rd, mem_addr
    );

    modport master (
        output load_enable, load_addr, load_size, mem_data,
        input  load_out, load_done, load_busy, load_trunc, load_count, mem_rd, mem_addr
    );
endinterface

// File: rtl/memory_loader.sv
// Reads a size*size block (capped at BUF_DEPTH) from single-port memory into a registered buffer.
// load_done rises N+2 cycles after acceptance and holds until load_enable drops (four-phase handshake).
module memory_loader #(
    parameter int DATA_SZ   = 16,
    parameter int ADDR_SZ   = 16,
    parameter int BUF_DEPTH = 1024,
    parameter int CNT_W     = $clog2(BUF_DEPTH) + 1
) (
    input  logic           clk,
    input  logic           reset,
    memory_loader_if.slave lif
);
    localparam int IDX_W = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     n_lat;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     wr_idx;
    logic                 rd_q;
    logic [2*DATA_SZ-1:0] prod;
    logic [CNT_W-1:0]     n_req;
    logic                 trunc_req;

    // Full-width product so oversize requests are never aliased into a small count.
    always_comb begin
        prod      = {{DATA_SZ{1'b0}}, lif.load_size} * {{DATA_SZ{1'b0}}, lif.load_size};
        trunc_req = (prod > (2*DATA_SZ)'(BUF_DEPTH));
        n_req     = trunc_req ? CNT_W'(BUF_DEPTH) : prod[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            n_lat          <= '0;
            cnt            <= '0;
            wr_idx         <= '0;
            rd_q           <= 1'b0;
            lif.load_done  <= 1'b0;
            lif.load_busy  <= 1'b0;
            lif.load_trunc <= 1'b0;
            lif.load_count <= '0;
            lif.mem_rd     <= 1'b0;
            lif.mem_addr   <= '0;
            for (int m = 0; m < BUF_DEPTH; m++) begin
                lif.load_out[m] <= '0;
            end
        end else begin
            // Read data lags the strobe by one cycle; rd_q marks the cycle it is valid.
            rd_q <= lif.mem_rd;
            if (rd_q) begin
                lif.load_out[wr_idx] <= lif.mem_data;
                wr_idx               <= wr_idx + IDX_W'(1);
            end

            case (state)
                IDLE: begin
                    if (lif.load_enable) begin
                        lif.load_count <= n_req;
                        lif.load_trunc <= trunc_req;
                        n_lat          <= n_req;
                        cnt            <= '0;
                        wr_idx         <= '0;
                        lif.mem_addr   <= lif.load_addr;
                        if (n_req == '0) begin
                            state         <= DONE;
                            lif.load_done <= 1'b1;
                        end else begin
                            state         <= READ;
                            lif.mem_rd    <= 1'b1;
                            lif.load_busy <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (cnt == n_lat - CNT_W'(1)) begin
                        lif.mem_rd <= 1'b0;
                        state      <= DRAIN;
                    end else begin
                        cnt          <= cnt + CNT_W'(1);
                        lif.mem_addr <= lif.mem_addr + ADDR_SZ'(1);
                    end
                end
                DRAIN: begin
                    state         <= DONE;
                    lif.load_busy <= 1'b0;
                    lif.load_done <= 1'b1;
                end
                DONE: begin
                    if (!lif.load_enable) begin
                        state         <= IDLE;
                        lif.load_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
